// File: rtl/deinter_frame_sync_if.sv
// Symbol bus between the deinterleaver, the frame synchroniser and the
// downstream consumer.  The master side drives symbols in; the slave side
// (the synchroniser) returns framed symbols and lock status.
interface deinter_frame_sync_if;
   logic [10:0] data_in;
   logic        en_in;
   logic [10:0] data_out;
   logic        valid_out;
   logic        sof;
   logic [10:0] sym_idx;
   logic        locked;
   logic [7:0]  sync_err_cnt;

   modport master (
      output data_in,
      output en_in,
      input  data_out,
      input  valid_out,
      input  sof,
      input  sym_idx,
      input  locked,
      input  sync_err_cnt
   );

   modport slave (
      input  data_in,
      input  en_in,
      output data_out,
      output valid_out,
      output sof,
      output sym_idx,
      output locked,
      output sync_err_cnt
   );
endinterface

// File: rtl/deinter_frame_sync.sv
// Frame synchroniser behind the deinterleaver.  Hunts for the sync word,
// confirms it recurs at the same frame position VERIFY_N more times, then
// flywheels through up to MISS_N-1 consecutive corrupted sync symbols.
// Only symbols of locked frames are flagged valid, tagged with their index.
module deinter_frame_sync #(
   parameter int          FRAME_LEN = 1536,
   parameter logic [10:0] SYNC_WORD = 11'h2B8,
   parameter int          VERIFY_N  = 2,
   parameter int          MISS_N    = 3
) (
   input logic                  clk,
   input logic                  rst,
   deinter_frame_sync_if.slave  bus
);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

   localparam logic [10:0] LAST_POS   = 11'(FRAME_LEN - 1);
   localparam logic [7:0]  VERIFY_LIM = 8'(VERIFY_N);
   localparam logic [7:0]  MISS_LIM   = 8'(MISS_N);

   state_t      r_state;
   logic [10:0] r_pos;
   logic [7:0]  r_hitCnt;
   logic [7:0]  r_missCnt;
   logic [7:0]  r_errCnt;
   logic [10:0] r_dataOut;
   logic [10:0] r_symIdx;
   logic        r_validOut;
   logic        r_sof;
   logic        r_locked;

   state_t      w_nextState;
   logic [10:0] w_nextPos;
   logic [7:0]  w_nextHit;
   logic [7:0]  w_nextMiss;
   logic [7:0]  w_nextErr;
   logic [10:0] w_curPos;
   logic [10:0] w_posAdv;
   logic        w_isSync;
   logic        w_atSync;
   logic [7:0]  w_hitInc;
   logic [7:0]  w_missInc;

   // While searching, a candidate sync symbol is by definition frame position 0.
   assign w_curPos  = (r_state == SEARCH) ? 11'd0 : r_pos;
   assign w_posAdv  = (w_curPos == LAST_POS) ? 11'd0 : w_curPos + 11'd1;
   assign w_isSync  = (bus.data_in == SYNC_WORD);
   assign w_atSync  = (w_curPos == 11'd0);
   assign w_hitInc  = r_hitCnt + 8'd1;
   assign w_missInc = r_missCnt + 8'd1;

   // Next-state logic: nothing moves unless a symbol is accepted this cycle.
   always_comb begin
      w_nextState = r_state;
      w_nextPos   = r_pos;
      w_nextHit   = r_hitCnt;
      w_nextMiss  = r_missCnt;
      w_nextErr   = r_errCnt;
      if (bus.en_in) begin
         case (r_state)
            SEARCH: begin
               if (w_isSync) begin
                  w_nextState = VERIFY;
                  w_nextPos   = w_posAdv;
                  w_nextHit   = 8'd0;
               end
            end
            VERIFY: begin
               w_nextPos = w_posAdv;
               if (w_atSync) begin
                  if (w_isSync) begin
                     w_nextHit = w_hitInc;
                     if (w_hitInc >= VERIFY_LIM) begin
                        w_nextState = LOCK;
                        w_nextMiss  = 8'd0;
                     end
                  end else begin
                     w_nextState = SEARCH;
                     w_nextPos   = 11'd0;
                  end
               end
            end
            LOCK: begin
               w_nextPos = w_posAdv;
               if (w_atSync) begin
                  if (w_isSync) begin
                     w_nextMiss = 8'd0;
                  end else begin
                     w_nextMiss = w_missInc;
                     if (r_errCnt != 8'hFF) begin
                        w_nextErr = r_errCnt + 8'd1;
                     end
                     if (w_missInc >= MISS_LIM) begin
                        w_nextState = SEARCH;
                        w_nextPos   = 11'd0;
                     end
                  end
               end
            end
            default: begin
               w_nextState = SEARCH;
               w_nextPos   = 11'd0;
            end
         endcase
      end
   end

   // State, counters and the output register; valid/sof drop on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= SEARCH;
         r_pos      <= 11'd0;
         r_hitCnt   <= 8'd0;
         r_missCnt  <= 8'd0;
         r_errCnt   <= 8'd0;
         r_dataOut  <= 11'd0;
         r_symIdx   <= 11'd0;
         r_validOut <= 1'b0;
         r_sof      <= 1'b0;
         r_locked   <= 1'b0;
      end else if (bus.en_in) begin
         r_state    <= w_nextState;
         r_pos      <= w_nextPos;
         r_hitCnt   <= w_nextHit;
         r_missCnt  <= w_nextMiss;
         r_errCnt   <= w_nextErr;
         r_dataOut  <= bus.data_in;
         r_symIdx   <= w_curPos;
         r_validOut <= (w_nextState == LOCK);
         r_sof      <= (w_nextState == LOCK) && w_atSync;
         r_locked   <= (w_nextState == LOCK);
      end else begin
         r_validOut <= 1'b0;
         r_sof      <= 1'b0;
      end
   end

   assign bus.data_out     = r_dataOut;
   assign bus.sym_idx      = r_symIdx;
   assign bus.valid_out    = r_validOut;
   assign bus.sof          = r_sof;
   assign bus.locked       = r_locked;
   assign bus.sync_err_cnt = r_errCnt;

endmodule

// File: tb/tb_deinter_frame_sync.sv
// Testbench for deinter_frame_sync: random payload symbols and idle gaps
// driven against a frame-level reference model, plus directed scenarios
// for acquisition, false sync, flywheel, gaps and reset while locked.
module tb_deinter_frame_sync;

   localparam int          FL   = 1536;
   localparam logic [10:0] SYNC = 11'h2B8;
   localparam int          VN   = 2;
   localparam int          MN   = 3;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   int   txPos;

   // Reference model: receiver phase (0 hunting, 1 confirming, 2 locked),
   // frame position of the next symbol, and the values the outputs should show.
   int          mPhase;
   int          mNextPos;
   int          mHits;
   int          mMisses;
   int          mErrs;
   logic [10:0] eData;
   int          eIdx;
   bit          eIdxKnown;
   bit          eValid;
   bit          eSof;
   bit          eLocked;

   deinter_frame_sync_if bus ();

   deinter_frame_sync #(
      .FRAME_LEN (FL),
      .SYNC_WORD (SYNC),
      .VERIFY_N  (VN),
      .MISS_N    (MN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, observed, observed, expected, expected, $time);
      end
   endtask

   function automatic logic [10:0] randPayload();
      logic [10:0] v;
      v = 11'($urandom_range(0, 2047));
      if (v == SYNC) v = v ^ 11'h001;
      return v;
   endfunction

   task automatic modelStep(input bit r, input bit en, input logic [10:0] d);
      int p;
      if (r) begin
         mPhase = 0; mNextPos = 0; mHits = 0; mMisses = 0; mErrs = 0;
         eData = 0; eIdx = 0; eIdxKnown = 1; eValid = 0; eSof = 0; eLocked = 0;
      end else if (!en) begin
         eValid = 0;
         eSof   = 0;
      end else begin
         p = (mPhase == 0) ? 0 : mNextPos;
         if (mPhase == 0) begin
            if (d == SYNC) begin
               mPhase = 1;
               mHits  = 0;
            end
         end else if (mPhase == 1) begin
            if (p == 0) begin
               if (d == SYNC) begin
                  mHits++;
                  if (mHits >= VN) begin
                     mPhase  = 2;
                     mMisses = 0;
                  end
               end else begin
                  mPhase = 0;
               end
            end
         end else begin
            if (p == 0) begin
               if (d == SYNC) mMisses = 0;
               else begin
                  mMisses++;
                  if (mErrs < 255) mErrs++;
                  if (mMisses >= MN) mPhase = 0;
               end
            end
         end
         mNextPos  = (p + 1) % FL;
         eData     = d;
         eValid    = (mPhase == 2);
         eSof      = eValid && (p == 0);
         eLocked   = (mPhase == 2);
         eIdx      = p;
         eIdxKnown = eValid;
      end
   endtask

   // Drive one cycle, let the edge happen, then compare every output to the model.
   task automatic applyStimulus(input bit r, input bit en, input logic [10:0] d);
      rst         = r;
      bus.en_in   = en;
      bus.data_in = d;
      @(posedge clk);
      #1;
      modelStep(r, en, d);
      checkOutput("valid_out", int'(bus.valid_out), int'(eValid));
      checkOutput("sof", int'(bus.sof), int'(eSof));
      checkOutput("locked", int'(bus.locked), int'(eLocked));
      checkOutput("sync_err_cnt", int'(bus.sync_err_cnt), mErrs);
      checkOutput("data_out", int'(bus.data_out), int'(eData));
      if (eIdxKnown) checkOutput("sym_idx", int'(bus.sym_idx), eIdx);
   endtask

   // Transmit the next symbol of the aligned stream, optionally corrupting sync.
   task automatic sendSym(input bit corrupt);
      logic [10:0] d;
      d = (txPos == 0 && !corrupt) ? SYNC : randPayload();
      applyStimulus(1'b0, 1'b1, d);
      txPos = (txPos + 1) % FL;
   endtask

   task automatic runTo(input int target, input int gapPct);
      while (txPos != target) begin
         if (int'($urandom_range(0, 99)) < gapPct)
            applyStimulus(1'b0, 1'b0, 11'($urandom_range(0, 2047)));
         else
            sendSym(1'b0);
      end
   endtask

   initial begin
      logic [10:0] d;
      testsRun = 0; testsFailed = 0; txPos = 0;
      modelStep(1'b1, 1'b0, 11'd0);
      rst = 1'b1; bus.en_in = 1'b1; bus.data_in = SYNC;

      // Reset held two edges with a sync word on the bus.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b1, SYNC);
         checkOutput("reset_valid", int'(bus.valid_out), 0);
         checkOutput("reset_locked", int'(bus.locked), 0);
         checkOutput("reset_data", int'(bus.data_out), 0);
      end

      // Acquisition: sync at stream symbols 5, 1541, 3077.
      for (int s = 0; s <= 3078; s++) begin
         d = (s == 5 || s == 1541 || s == 3077) ? SYNC : randPayload();
         applyStimulus(1'b0, 1'b1, d);
         if (s == 3076) checkOutput("acq_not_yet_locked", int'(bus.locked), 0);
         if (s == 3077) begin
            checkOutput("acq_locked", int'(bus.locked), 1);
            checkOutput("acq_sof", int'(bus.sof), 1);
            checkOutput("acq_idx0", int'(bus.sym_idx), 0);
            checkOutput("acq_data", int'(bus.data_out), 'h2B8);
         end
         if (s == 3078) begin
            checkOutput("acq_idx1", int'(bus.sym_idx), 1);
            checkOutput("acq_sof_low", int'(bus.sof), 0);
         end
      end
      txPos = (3079 - 5) % FL;

      // Locked stream with random idle gaps.
      runTo(0, 20);
      runTo(FL / 2, 20);

      // Flywheel: two tolerated sync misses, the third drops lock.
      runTo(0, 10);
      sendSym(1'b1);
      checkOutput("fly1_locked", int'(bus.locked), 1);
      checkOutput("fly1_sof", int'(bus.sof), 1);
      checkOutput("fly1_err", int'(bus.sync_err_cnt), 1);
      runTo(0, 10);
      sendSym(1'b1);
      checkOutput("fly2_locked", int'(bus.locked), 1);
      checkOutput("fly2_err", int'(bus.sync_err_cnt), 2);
      runTo(0, 10);
      sendSym(1'b1);
      checkOutput("fly3_locked", int'(bus.locked), 0);
      checkOutput("fly3_valid", int'(bus.valid_out), 0);
      checkOutput("fly3_err", int'(bus.sync_err_cnt), 3);

      // Reacquire; the error count survives loss of lock.
      for (int k = 0; k < 3; k++) begin
         runTo(0, 10);
         sendSym(1'b0);
      end
      checkOutput("reacq_locked", int'(bus.locked), 1);
      checkOutput("reacq_err_kept", int'(bus.sync_err_cnt), 3);

      // Seven idle cycles right after sym_idx 100 is output.
      runTo(101, 0);
      for (int g = 0; g < 7; g++) begin
         applyStimulus(1'b0, 1'b0, SYNC);
         checkOutput("gap_valid", int'(bus.valid_out), 0);
         checkOutput("gap_idx_hold", int'(bus.sym_idx), 100);
      end
      sendSym(1'b0);
      checkOutput("gap_next_idx", int'(bus.sym_idx), 101);
      checkOutput("gap_next_valid", int'(bus.valid_out), 1);

      // Reset for one edge while sym_idx 700 is on the output.
      runTo(701, 0);
      applyStimulus(1'b1, 1'b1, randPayload());
      txPos = (txPos + 1) % FL;
      checkOutput("rst_mid_locked", int'(bus.locked), 0);
      checkOutput("rst_mid_valid", int'(bus.valid_out), 0);
      checkOutput("rst_mid_err", int'(bus.sync_err_cnt), 0);

      // False sync: a lone sync word at symbol 10, symbol 1546 is 0.
      for (int s = 0; s <= 1546; s++) begin
         d = (s == 10) ? SYNC : ((s == 1546) ? 11'h000 : randPayload());
         applyStimulus(1'b0, 1'b1, d);
         checkOutput("false_sync_valid", int'(bus.valid_out), 0);
      end
      checkOutput("false_sync_locked", int'(bus.locked), 0);

      // A genuine sync sequence still acquires, needing all verification hits.
      txPos = 0;
      sendSym(1'b0);
      checkOutput("fresh_search_hit", int'(bus.locked), 0);
      runTo(0, 10);
      sendSym(1'b0);
      checkOutput("fresh_verify_hit1", int'(bus.locked), 0);
      runTo(0, 10);
      sendSym(1'b0);
      checkOutput("fresh_locked", int'(bus.locked), 1);
      checkOutput("fresh_sof", int'(bus.sof), 1);

      // Random tail: gaps and randomly corrupted sync positions.
      for (int f = 0; f < 4; f++) begin
         runTo(0, 15);
         sendSym(bit'($urandom_range(0, 1)));
      end
      runTo(50, 15);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/deinter_frame_sync.md
DEINTER_FRAME_SYNC -- requirements
Module: deinter_frame_sync

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1536, symbols per frame including sync symbol.
REQ-002 SHALL have parameter SYNC_WORD, default 11'h2B8, value of frame symbol 0.
REQ-003 SHALL have parameter VERIFY_N, default 2, consecutive sync hits after first detection needed to lock.
REQ-004 SHALL have parameter MISS_N, default 3, consecutive sync misses in lock that drop lock.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port data_in  input  11  deinterleaved symbol from the deinterleaver stage.
REQ-008 SHALL have port en_in  input  1  data_in valid this cycle.
REQ-009 SHALL have port data_out  output  11  registered symbol.
REQ-010 SHALL have port valid_out  output  1  data_out valid (locked frames only).
REQ-011 SHALL have port sof  output  1  start of frame; high with valid_out for symbol index 0.
REQ-012 SHALL have port sym_idx  output  11  index of data_out within frame, 0..FRAME_LEN-1.
REQ-013 SHALL have port locked  output  1  high while state is LOCK.
REQ-014 SHALL have port sync_err_cnt  output  8  saturating count of sync misses seen in LOCK.

Function
REQ-015 SHALL implement states SEARCH, VERIFY, LOCK; all state, counters and outputs change only on cycles with en_in=1, except valid_out/sof which deassert on any cycle with en_in=0.
REQ-016 SHALL keep an internal position counter pos (0..FRAME_LEN-1) giving the frame index of the current accepted symbol; pos wraps FRAME_LEN-1 -> 0.
REQ-017 SEARCH: accepted symbol == SYNC_WORD -> VERIFY, that symbol is pos 0, hit count 0; otherwise stay, pos ignored.
REQ-018 VERIFY: at pos 0, symbol == SYNC_WORD -> hit count +1; if hit count reaches VERIFY_N -> LOCK on same edge; symbol != SYNC_WORD at pos 0 -> SEARCH, that symbol is not re-evaluated as a new sync.
REQ-019 LOCK: at pos 0, hit -> miss count cleared; miss -> miss count +1 and sync_err_cnt +1 (saturate at 255); miss count reaching MISS_N -> SEARCH on same edge.
REQ-020 Latency SHALL be exactly 1 cycle: symbol accepted at edge N appears on data_out/sym_idx after edge N.
REQ-021 valid_out SHALL be 1 for an accepted symbol iff the next state is LOCK; the symbol completing verification is output (sof=1, sym_idx=0); the symbol causing the MISS_N-th miss is not output.
REQ-022 sof SHALL equal valid_out AND (output pos == 0); sync misses tolerated in LOCK still produce sof=1 with the received (corrupt) data_out.
REQ-023 locked SHALL be registered, updating on the same edge as state, thus coincident with the first valid_out.
REQ-024 When en_in=0: data_out and sym_idx hold; valid_out=0; sof=0; pos and state unchanged.
REQ-025 sync_err_cnt SHALL clear only on reset, not on loss or reacquisition of lock.
REQ-026 Counters SHALL be sized so FRAME_LEN up to 2047 works without overflow.

Reset
REQ-027 With rst=1 at a rising edge, state SHALL become SEARCH, pos, hit and miss counts 0, and data_out=0, valid_out=0, sof=0, sym_idx=0, locked=0, sync_err_cnt=0, regardless of en_in or current state.
REQ-028 A reset asserted mid-LOCK SHALL take effect at that edge; the first symbol after reset release is evaluated in SEARCH.

Verification
REQ-029 Reset: rst=1 for 2 cycles with en_in=1 and data_in=SYNC_WORD -> all outputs 0 after each of those edges.
REQ-030 Acquisition: continuous en_in, SYNC_WORD at stream symbols 5, 1541, 3077 -> locked and first valid_out one cycle after symbol 3077 accepted, with sof=1, sym_idx=0, data_out=11'h2B8; symbol 3078 out with sym_idx=1, sof=0.
REQ-031 False sync: SYNC_WORD at symbol 10 only, symbol 1546=11'h000 -> locked stays 0, valid_out never 1; a later valid sync sequence still acquires.
REQ-032 Flywheel: locked; sync positions of next 2 frames corrupted -> locked stays 1, sof still pulses, sync_err_cnt=2; third consecutive corruption -> locked=0 and valid_out=0 from that symbol, sync_err_cnt=3.
REQ-033 Gaps: locked, en_in=0 for 7 cycles at sym_idx=100 -> valid_out=0 for those 7 cycles, next accepted symbol output with sym_idx=101, no skip.
REQ-034 Reset mid-lock: rst=1 one cycle at sym_idx=700 -> next edge locked=0, valid_out=0, sync_err_cnt=0; reacquisition needs fresh SEARCH + VERIFY_N hits.
